// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding,
// default frame geometry and the parity helper.
package serial_frame_rx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        PARITY  = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } rx_state_e;

    localparam int unsigned DEFAULT_DATA_W    = 8;
    localparam bit          DEFAULT_PARITY_EN = 1'b1;
    localparam int unsigned MAX_DATA_W        = 16;

    // Even-parity sum; narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// Output holding register for received words: valid/ready handshake and
// overrun detection when a completed frame finds the register still occupied.
module rx_hold_reg
    import serial_frame_rx_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_perr,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              overrun
);

    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic              perr_r;
    logic              overrun_r;

    // Hold register update: a completed frame takes priority over the consumer drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r    <= '0;
            valid_r   <= 1'b0;
            perr_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (load) begin
                if (!valid_r || data_ready) begin
                    data_r  <= load_data;
                    perr_r  <= load_perr;
                    valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && data_ready) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign data_out   = data_r;
    assign data_valid = valid_r;
    assign parity_err = perr_r;
    assign overrun    = overrun_r;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even
// parity and a stop bit, one bit per clock, delivered through rx_hold_reg.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter bit          PARITY_EN = DEFAULT_PARITY_EN
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

    rx_state_e         state_r;
    logic [4:0]        bit_cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic              perr_r;
    logic              busy_r;
    logic              frame_err_r;
    logic              frame_done_s;

    // Frame completion is a good stop bit; the hold register captures on that same edge.
    always_comb begin
        frame_done_s = 1'b0;
        if ((state_r == STOP) && serial_in) begin
            frame_done_s = 1'b1;
        end else begin
            frame_done_s = 1'b0;
        end
    end

    // Receive FSM with bit counter, shifter and registered busy / frame_err.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 5'd0;
            shift_r     <= '0;
            perr_r      <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!serial_in) begin
                        state_r   <= DATA;
                        bit_cnt_r <= 5'd0;
                        perr_r    <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                DATA: begin
                    shift_r   <= {serial_in, shift_r[DATA_W-1:1]};
                    bit_cnt_r <= bit_cnt_r + 5'd1;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_r <= PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    perr_r  <= serial_in ^ even_parity(MAX_DATA_W'(shift_r));
                    state_r <= STOP;
                end
                STOP: begin
                    if (serial_in) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r     <= RECOVER;
                        frame_err_r <= 1'b1;
                    end
                end
                // A low line here is the tail of a broken frame, never a start bit.
                RECOVER: begin
                    if (serial_in) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    rx_hold_reg #(
        .DATA_W(DATA_W)
    ) u_hold (
        .clk        (clk),
        .rst_n      (Rst),
        .load       (frame_done_s),
        .load_data  (shift_r),
        .load_perr  (perr_r),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    assign busy      = busy_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed frames plus random traffic
// compared against a frame-level reference model.
module tb_serial_frame_rx;

    logic       clk;
    logic       Rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vec_cnt;
    int err_cnt;

    // Reference model: contents of the delivery register and expected pulses.
    logic       mdl_valid;
    logic [7:0] mdl_data;
    logic       mdl_perr;
    logic       mdl_ferr;
    logic       mdl_ovr;

    serial_frame_rx #(
        .DATA_W    (8),
        .PARITY_EN (1'b1)
    ) dut (
        .clk        (clk),
        .Rst        (Rst),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (got !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_valid = 1'b0;
        mdl_data  = 8'h00;
        mdl_perr  = 1'b0;
        mdl_ferr  = 1'b0;
        mdl_ovr   = 1'b0;
    endtask

    task automatic check_outputs(input logic busy_exp);
        check_val("data_valid", {31'd0, data_valid}, {31'd0, mdl_valid});
        check_val("busy", {31'd0, busy}, {31'd0, busy_exp});
        check_val("frame_err", {31'd0, frame_err}, {31'd0, mdl_ferr});
        check_val("overrun", {31'd0, overrun}, {31'd0, mdl_ovr});
        if (mdl_valid) begin
            check_val("data_out", {24'd0, data_out}, {24'd0, mdl_data});
            check_val("parity_err", {31'd0, parity_err}, {31'd0, mdl_perr});
        end
    endtask

    // ev: 0 = ordinary bit, 1 = good stop bit completes word d with parity flag pe,
    // 2 = bad stop bit. busy_exp is the expected busy level after this edge.
    task automatic tick(input logic line, input logic rdy, input int ev,
                        input logic [7:0] d, input logic pe, input logic busy_exp);
        @(negedge clk);
        serial_in  = line;
        data_ready = rdy;
        @(posedge clk);
        #1;
        mdl_ferr = (ev == 2);
        mdl_ovr  = 1'b0;
        if (ev == 1) begin
            if (!mdl_valid || rdy) begin
                mdl_valid = 1'b1;
                mdl_data  = d;
                mdl_perr  = pe;
            end else begin
                mdl_ovr = 1'b1;
            end
        end else if (mdl_valid && rdy) begin
            mdl_valid = 1'b0;
        end
        check_outputs(busy_exp);
    endtask

    function automatic logic pick_rdy(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return (mode == 1);
    endfunction

    // Whole frame; par_flip sends odd parity, stop is the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop, input int mode);
        logic p;
        tick(1'b0, pick_rdy(mode), 0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(d[i], pick_rdy(mode), 0, 8'h00, 1'b0, 1'b1);
        end
        p = (^d) ^ par_flip;
        tick(p, pick_rdy(mode), 0, 8'h00, 1'b0, 1'b1);
        if (stop) begin
            tick(1'b1, pick_rdy(mode), 1, d, par_flip, 1'b0);
        end else begin
            tick(1'b0, pick_rdy(mode), 2, 8'h00, 1'b0, 1'b1);
        end
    endtask

    task automatic idle(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, pick_rdy(mode), 0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    // Line held low after a bad stop bit, then released high.
    task automatic recover(input int low_cycles, input int mode);
        for (int i = 0; i < low_cycles; i++) begin
            tick(1'b0, pick_rdy(mode), 0, 8'h00, 1'b0, 1'b1);
        end
        tick(1'b1, pick_rdy(mode), 0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        Rst        = 1'b0;
        serial_in  = 1'b1;
        data_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs(1'b0);
        @(negedge clk);
        Rst = 1'b1;
        idle(2, 1);

        // 0xA5, correct parity, consumer always ready: one-cycle valid on the stop edge
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        idle(2, 1);

        // 0x3C with wrong parity
        send_frame(8'h3C, 1'b1, 1'b1, 1);
        idle(2, 1);

        // Back-to-back with consumer stalled: second frame dropped with overrun
        send_frame(8'h11, 1'b0, 1'b1, 0);
        send_frame(8'h22, 1'b0, 1'b1, 0);
        idle(3, 0);
        idle(2, 1);

        // Bad stop bit, line low for 5 more cycles
        send_frame(8'h77, 1'b0, 1'b0, 1);
        recover(5, 1);
        idle(2, 1);

        // Reset in the middle of a frame after 4 data bits
        tick(1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b1);
        end
        @(negedge clk);
        Rst = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs(1'b0);
        @(negedge clk);
        Rst = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        idle(2, 1);

        // Random traffic: random data, parity, stop errors, gaps and ready patterns
        for (int f = 0; f < 40; f++) begin
            logic [7:0] d;
            logic       flip;
            logic       stop;
            int         mode;
            d    = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 5) != 0);
            mode = int'($urandom_range(0, 2));
            send_frame(d, flip, stop, mode);
            if (!stop) begin
                recover(int'($urandom_range(0, 3)), mode);
            end
            idle(int'($urandom_range(0, 2)), mode);
        end
        idle(3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the number of data bits per frame (range 5..16).
REQ-002 The block SHALL have parameter PARITY_EN, default 1: 1 = even parity bit present after the data bits, 0 = no parity bit.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port serial_in, input, 1 bit: serial line, one bit per clk, idles high.
REQ-006 The block SHALL have port data_out, output, DATA_W bits: received word, LSB = first data bit.
REQ-007 The block SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed word.
REQ-008 The block SHALL have port data_ready, input, 1 bit: consumer accepts data_out this cycle.
REQ-009 The block SHALL have port parity_err, output, 1 bit: parity flag of the word in data_out, qualified by data_valid.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 Frame format SHALL be: start (0), DATA_W data bits LSB first, parity (if PARITY_EN), stop (1), each bit sampled once on one clk edge.
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP and RECOVER.
REQ-015 IDLE SHALL go to DATA on a sampled serial_in=0 and stay in IDLE on 1.
REQ-016 DATA SHALL shift serial_in into a DATA_W shift register for exactly DATA_W edges, counted by a bit counter cleared on entry.
REQ-017 After the last data bit, DATA SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-018 PARITY SHALL record the mismatch between the sampled bit and the XOR of the data bits (even parity), then go to STOP.
REQ-019 STOP with serial_in=1 SHALL complete the frame and go to IDLE.
REQ-020 STOP with serial_in=0 SHALL discard the frame, pulse frame_err for one cycle and go to RECOVER.
REQ-021 RECOVER SHALL stay until serial_in=1 is sampled, then go to IDLE; a low line SHALL never be taken as a new start bit.
REQ-022 On frame completion with the holding register empty, or with data_valid=1 and data_ready=1 in the same cycle, data_out, parity_err and data_valid=1 SHALL be loaded on the stop-bit sampling edge.
REQ-023 Latency SHALL be DATA_W+2+PARITY_EN edges from the start-bit sample to data_valid visible; for DATA_W=8, PARITY_EN=1 that is the 11th edge.
REQ-024 data_valid SHALL clear on the edge where data_valid=1 and data_ready=1 and no new frame completes.
REQ-025 data_out and parity_err SHALL stay stable while data_valid=1 and data_ready=0.
REQ-026 On frame completion with data_valid=1 and data_ready=0, the new frame SHALL be dropped, the held word kept, and overrun pulsed for one cycle.
REQ-027 Back-to-back frames (start bit on the edge after the stop bit) SHALL be received without loss.

Reset
REQ-028 While Rst=0, the FSM SHALL be in IDLE and the bit counter and shift register SHALL be 0.
REQ-029 While Rst=0, data_out, data_valid, parity_err, frame_err, overrun and busy SHALL all be 0.
REQ-030 Reset mid-frame SHALL abandon the partial frame with no pulse on any flag; reception SHALL resume from IDLE on the first edge after Rst rises.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, DATA, PARITY, STOP, RECOVER) and the DATA_W and PARITY_EN default constants.
REQ-032 The output holding register and its valid/ready/overrun logic SHALL be a sub-module rx_hold_reg; the FSM, counter and shifter SHALL stay in serial_frame_rx.

Verification
REQ-033 Bench SHALL send 0xA5 with parity 0 and stop 1, data_ready=1 -> data_out=0xA5, parity_err=0, data_valid on the 11th edge after the start sample for one cycle.
REQ-034 Bench SHALL send 0x3C with parity 1 -> data_out=0x3C, parity_err=1, data_valid=1.
REQ-035 Bench SHALL send 0x11 then 0x22 back-to-back with data_ready=0 -> data_out stays 0x11 and overrun pulses once at the 0x22 stop; after data_ready=1, data_valid clears.
REQ-036 Bench SHALL send a frame with stop bit 0 and hold the line low for 5 cycles -> frame_err pulses once, busy stays 1 until the line returns high, and no data_valid occurs.
REQ-037 Bench SHALL assert Rst=0 after 4 data bits, release it, then send 0x5A -> only 0x5A is delivered and no flag pulses.
